// File: rtl/sam_pkg.sv
// Shared SAM link definitions: receiver FSM states and default link widths.
package sam_pkg;

  localparam int unsigned SAM_WIDTH = 16;
  localparam int unsigned SAM_CNT_W = 10;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } sam_state_e;

endpackage

// File: rtl/sam_in_buf.sv
// One-entry valid/ready holding register; a load into a full, stalled buffer
// is dropped and flagged with a one-cycle overrun pulse.
module sam_in_buf #(
  parameter int unsigned DW = 27
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          overrun
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          overrun_q, overrun_d;

  // A load wins over an accept of the old entry in the same cycle.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (load) begin
      if (!valid_q || ready) begin
        valid_d = 1'b1;
        data_d  = load_data;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid   = valid_q;
  assign data    = data_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/sam_in.sv
// SAM link receiver: deserialises msg/frame bursts into a right-aligned message
// and bit count, presented through a one-entry valid/ready buffer.
module sam_in
  import sam_pkg::*;
#(
  parameter int unsigned WIDTH = SAM_WIDTH,
  parameter int unsigned CNT_W = SAM_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             msg,
  input  logic             frame,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] mesgcd,
  output logic [CNT_W-1:0] cc,
  output logic             err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned DW = WIDTH + CNT_W + 1;

  sam_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             commit_c;
  logic             err_c;
  logic [DW-1:0]    buf_data;

  assign err_c = (32'(count_q) > WIDTH);

  // SYNC swallows any burst already in flight when reset releases.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    commit_c = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (!frame) state_d = IDLE;
      end
      IDLE: begin
        if (frame) begin
          shift_d = WIDTH'(msg);
          count_d = CNT_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (frame) begin
          shift_d = {shift_q[WIDTH-2:0], msg};
          if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
        end else begin
          commit_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC;
      shift_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  sam_in_buf #(
    .DW(DW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (commit_c),
    .load_data({shift_q, count_q, err_c}),
    .ready    (ready),
    .valid    (valid),
    .data     (buf_data),
    .overrun  (overrun)
  );

  assign {mesgcd, cc, err} = buf_data;
  assign busy = busy_q;

endmodule

// File: doc/sam_in.md
Name: sam_in

Overview:
- Receive end of the SAM serial link. Deserialises the msg/frame bit stream produced by the SAM transmitter back into a parallel encoded message plus its bit count.
- Presents each completed message on a one-entry valid/ready output buffer for the downstream decoder.
- Sits between the serial link pins and the SAM decode/norm logic.

Parameters:
- WIDTH, 16: maximum message width in bits; width of the mesgcd output.
- CNT_W, 10: width of the bit-count output cc.

Ports:
- clk, input, 1: single clock. One clock; reset is asynchronous and active-high.
- reset, input, 1: asynchronous, active-high reset.
- msg, input, 1: serial data, MSB first. Valid on every rising clk edge where frame=1.
- frame, input, 1: high for exactly the message's bit periods, one contiguous burst per message.
- ready, input, 1: downstream accepts the buffered message when valid&&ready.
- valid, output, 1: output buffer holds a completed message.
- mesgcd, output, WIDTH: received message, right-aligned. Bit 0 is the last bit received.
- cc, output, CNT_W: number of bits received in the frame.
- err, output, 1: frame carried more than WIDTH bits.
- overrun, output, 1: one-cycle pulse when a completed frame is dropped because the buffer was full.
- busy, output, 1: a frame is currently being received (state RECV).

Behaviour:
- All sampling is on the rising edge of clk. frame and msg are synchronous to clk.
- Reset (asynchronous assert, any time): state goes to SYNC and the shift register and count clear. valid, mesgcd, cc, err, overrun and busy all reset to 0.
- FSM states:
  - SYNC: wait for frame=0. Moves to IDLE on the first edge with frame=0. This prevents capturing a partial frame when reset releases mid-burst.
  - IDLE: on frame=1, load shift = {0…, msg} and count = 1, then go to RECV. On frame=0, stay.
  - RECV: on frame=1, shift = {shift[WIDTH-2:0], msg} and count += 1. Count saturates at 2^CNT_W-1 and does not wrap. On frame=0, commit (below) and go to IDLE.
- Commit, on the first frame=0 edge in RECV:
  - The result is mesgcd=shift, cc=count, err=(count>WIDTH).
  - If more than WIDTH bits were received, the last WIDTH bits are retained.
  - If the buffer is empty, or is full and ready=1 in the same cycle, load the result and set valid=1 on the next cycle.
  - Otherwise keep the old buffer contents and pulse overrun=1 for one cycle.
- Latency: valid rises 1 cycle after the edge on which frame is sampled low. So a frame with frame high on edges n..n+k-1 gives valid=1 after edge n+k.
- Output buffer:
  - valid clears on an edge where valid&&ready and no commit occurs.
  - mesgcd/cc/err hold stable while valid=1 and ready=0.
- Back-to-back frames: one idle edge with frame=0 between frames is sufficient. A new frame can start in IDLE on the edge immediately after the commit edge.
- Single-bit frame: cc=1, mesgcd={0…,msg}.
- busy=1 exactly while the state is RECV.

Decomposition:
- Shared package sam_pkg:
  - state enum {SYNC, IDLE, RECV};
  - default WIDTH/CNT_W constants, also used by the transmitter.
- One natural sub-module, sam_in_buf: a one-entry valid/ready holding register with load/accept/overrun logic.
- The FSM and shift register stay in sam_in.

Test Plan:
- 8-bit frame of bits 1,0,1,1,0,0,1,0 with ready=1 -> one cycle after frame falls: valid=1, mesgcd=16'h00B2, cc=8, err=0. valid drops next cycle.
- 16-bit frame of 16'hA5C3, then a 1-cycle gap, then a 3-bit frame of 1,1,0, ready=1 -> two results in order: 16'hA5C3/cc=16, then 16'h0006/cc=3. No overrun.
- 20-bit frame with last 16 bits 16'h1234 -> mesgcd=16'h1234, cc=20, err=1.
- Hold ready=0 and send two frames (16'h00FF/8 bits, then 16'h000F/4 bits) -> buffer keeps 16'h00FF/cc=8. overrun pulses once at the second commit. Raise ready -> 16'h00FF accepted, then valid=0.
- Assert reset mid-frame (after 5 bits), release while frame=1 -> busy=0, nothing output for the remaining bits. The next full frame 16'h0003/2 bits is received correctly.
- Drive frame=1 for exactly one edge with msg=1 -> mesgcd=16'h0001, cc=1, busy high for exactly one cycle.
